// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce-sweep hasher and its result scanner.
// Result record layout: bitmap word, status word, best hash word.
package bitcoin_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } scan_state_e;

  localparam int unsigned NUM_NONCES_DEFAULT = 16;
  localparam int unsigned RESULT_WORDS       = 3;

  localparam logic [1:0] RES_BITMAP = 2'd0;
  localparam logic [1:0] RES_STATUS = 2'd1;
  localparam logic [1:0] RES_BEST   = 2'd2;

  localparam int unsigned STAT_FOUND_BIT = 31;
  localparam int unsigned STAT_COUNT_LSB = 16;
  localparam int unsigned STAT_BEST_LSB  = 0;

  function automatic logic [31:0] pack_status(input logic       found,
                                              input logic [7:0] count,
                                              input logic [7:0] best);
    logic [31:0] w;
    w = '0;
    w[STAT_FOUND_BIT]         = found;
    w[STAT_COUNT_LSB +: 8]    = count;
    w[STAT_BEST_LSB +: 8]     = best;
    return w;
  endfunction

endpackage

// File: rtl/nonce_best_tracker.sv
// Registered compare/accumulate unit: tracks which nonces beat the target, how many,
// and the smallest matching hash (lowest index wins ties).
module nonce_best_tracker (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [4:0]  idx_i,
  input  logic [31:0] hash_i,
  input  logic [31:0] target_i,
  output logic [31:0] bitmap_o,
  output logic [7:0]  count_o,
  output logic [7:0]  best_nonce_o,
  output logic [31:0] best_hash_o
);

  logic [31:0] bitmap_q, bitmap_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  best_nonce_q, best_nonce_d;
  logic [31:0] best_hash_q, best_hash_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitmap_q     <= '0;
      count_q      <= '0;
      best_nonce_q <= '0;
      best_hash_q  <= 32'hFFFF_FFFF;
    end else begin
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      best_nonce_q <= best_nonce_d;
      best_hash_q  <= best_hash_d;
    end
  end

  always_comb begin
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    best_nonce_d = best_nonce_q;
    best_hash_d  = best_hash_q;
    if (clear_i) begin
      bitmap_d     = '0;
      count_d      = '0;
      best_nonce_d = '0;
      best_hash_d  = 32'hFFFF_FFFF;
    end else if (valid_i && (hash_i < target_i)) begin
      bitmap_d = bitmap_q | (32'h1 << idx_i);
      count_d  = count_q + 8'd1;
      // Strict less-than keeps the earlier nonce on equal hashes.
      if (hash_i < best_hash_q) begin
        best_hash_d  = hash_i;
        best_nonce_d = {3'b000, idx_i};
      end
    end
  end

  assign bitmap_o     = bitmap_q;
  assign count_o      = count_q;
  assign best_nonce_o = best_nonce_q;
  assign best_hash_o  = best_hash_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Reads back the hasher's per-nonce H0 words, compares them to a latched target and
// writes a three-word result record. Define SCAN_EARLY_EXIT_EN to stop at the first match.
module nonce_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_in_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] memory_addr,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [7:0]  match_count
);

  localparam logic [5:0] LastReadIdx  = 6'(NUM_NONCES);
  localparam logic [5:0] LastWriteIdx = 6'(RESULT_WORDS - 1);

  scan_state_e state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] target_q, target_d;

  logic        trk_clear;
  logic        trk_valid;
  logic [4:0]  trk_idx;
  logic [31:0] trk_bitmap;
  logic [31:0] trk_best_hash;

  assign mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
    end
  end

  // Read cycle j compares the word addressed in cycle j-1.
  assign trk_valid = (state_q == StRead) && (idx_q != 6'd0);
  assign trk_idx   = idx_q[4:0] - 5'd1;

`ifdef SCAN_EARLY_EXIT_EN
  logic read_match;
  assign read_match = trk_valid && (memory_read_data < target_q);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    target_d  = target_q;
    trk_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRead;
          idx_d     = '0;
          target_d  = target;
          trk_clear = 1'b1;
        end
      end
      StRead: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LastReadIdx) begin
          state_d = StWrite;
          idx_d   = '0;
        end
`ifdef SCAN_EARLY_EXIT_EN
        else if (read_match) begin
          state_d = StWrite;
          idx_d   = '0;
        end
`endif
      end
      StWrite: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LastWriteIdx) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    done              = 1'b0;
    mem_we            = 1'b0;
    memory_addr       = hash_in_addr;
    memory_write_data = '0;
    unique case (state_q)
      StIdle: done = 1'b1;
      StRead: memory_addr = hash_in_addr + {10'b0, idx_q};
      StWrite: begin
        mem_we      = 1'b1;
        memory_addr = result_addr + {10'b0, idx_q};
        case (idx_q[1:0])
          RES_BITMAP: memory_write_data = trk_bitmap;
          RES_STATUS: memory_write_data = pack_status(found, match_count, best_nonce);
          RES_BEST:   memory_write_data = trk_best_hash;
          default:    memory_write_data = '0;
        endcase
      end
      default: done = 1'b0;
    endcase
  end

  assign found = (match_count != 8'd0);

  nonce_best_tracker u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (trk_clear),
    .valid_i      (trk_valid),
    .idx_i        (trk_idx),
    .hash_i       (memory_read_data),
    .target_i     (target_q),
    .bitmap_o     (trk_bitmap),
    .count_o      (match_count),
    .best_nonce_o (best_nonce),
    .best_hash_o  (trk_best_hash)
  );

endmodule
